// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//   RV32I decode stage with a valid/ready handshake on both sides. It has one
//   output register plus one skid register, so in_ready is a plain register
//   (it is NOT skid_valid) and never depends combinationally on out_ready.
//   Ports:
//     clk, rst (sync, active-high), flush (sync pipeline flush)
//     in_valid/in_ready/in_instr/in_pc      : fetch side
//     out_valid/out_ready/out_pc            : downstream side
//     rd, rs1, rs2, funct3, funct7_5, imm, op_class,
//     reg_write, mem_read, mem_write, is_imm, illegal : decoded fields
//     decoded_count (wraps), illegal_count (saturates) : transfer counters
//
// The opcode and funct3 names match the shared RV32I defines header. They are
// guarded, so the definitions of that header are used when it is included first.
`ifndef OPCODE_LUI
  `define OPCODE_LUI    7'b0110111
  `define OPCODE_AUIPC  7'b0010111
  `define OPCODE_JAL    7'b1101111
  `define OPCODE_JALR   7'b1100111
  `define OPCODE_BRANCH 7'b1100011
  `define OPCODE_LOAD   7'b0000011
  `define OPCODE_STORE  7'b0100011
  `define OPCODE_OP_IMM 7'b0010011
  `define OPCODE_OP     7'b0110011
  `define OPCODE_FENCE  7'b0001111
  `define OPCODE_SYSTEM 7'b1110011
`endif
`ifndef FUNCT3_LB
  `define FUNCT3_LB      3'b000
  `define FUNCT3_LH      3'b001
  `define FUNCT3_LW      3'b010
  `define FUNCT3_LBU     3'b100
  `define FUNCT3_LHU     3'b101
  `define FUNCT3_SB      3'b000
  `define FUNCT3_SH      3'b001
  `define FUNCT3_SW      3'b010
  `define FUNCT3_BEQ     3'b000
  `define FUNCT3_BNE     3'b001
  `define FUNCT3_BLT     3'b100
  `define FUNCT3_BGE     3'b101
  `define FUNCT3_BLTU    3'b110
  `define FUNCT3_BGEU    3'b111
  `define FUNCT3_JALR    3'b000
  `define FUNCT3_ADD_SUB 3'b000
  `define FUNCT3_SLL     3'b001
  `define FUNCT3_SRL_SRA 3'b101
`endif

module instr_decode_stage #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [4:0]           rd,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [2:0]           funct3,
  output logic                 funct7_5,
  output logic [31:0]          imm,
  output logic [3:0]           op_class,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 is_imm,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] decoded_count,
  output logic [15:0]          illegal_count
);

  localparam logic [3:0] CLS_LUI = 4'd0, CLS_AUIPC = 4'd1, CLS_JAL = 4'd2,
    CLS_JALR = 4'd3, CLS_BRANCH = 4'd4, CLS_LOAD = 4'd5, CLS_STORE = 4'd6,
    CLS_OP_IMM = 4'd7, CLS_OP = 4'd8, CLS_FENCE = 4'd9, CLS_SYSTEM = 4'd10,
    CLS_ILLEGAL = 4'd15;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] imm;
    logic [3:0]  op_class;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_imm;
    logic        illegal;
  } dec_t;

  dec_t dec_d, out_q, skid_q;
  logic skid_valid;

  // ---------------- combinational decode of the incoming word ----------------
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [3:0]  cls;
  logic        bad;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'h000};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  always_comb begin
    cls = CLS_ILLEGAL;
    bad = 1'b0;
    case (opc)
      `OPCODE_LUI:    cls = CLS_LUI;
      `OPCODE_AUIPC:  cls = CLS_AUIPC;
      `OPCODE_JAL:    cls = CLS_JAL;
      `OPCODE_JALR:   begin cls = CLS_JALR;   bad = (f3 != `FUNCT3_JALR); end
      `OPCODE_BRANCH: begin
        cls = CLS_BRANCH;
        bad = !(f3 inside {`FUNCT3_BEQ, `FUNCT3_BNE, `FUNCT3_BLT, `FUNCT3_BGE,
                           `FUNCT3_BLTU, `FUNCT3_BGEU});
      end
      `OPCODE_LOAD:   begin
        cls = CLS_LOAD;
        bad = !(f3 inside {`FUNCT3_LB, `FUNCT3_LH, `FUNCT3_LW, `FUNCT3_LBU, `FUNCT3_LHU});
      end
      `OPCODE_STORE:  begin
        cls = CLS_STORE;
        bad = !(f3 inside {`FUNCT3_SB, `FUNCT3_SH, `FUNCT3_SW});
      end
      `OPCODE_OP_IMM: begin
        cls = CLS_OP_IMM;
        // Only shifts carry a funct7; SRAI is the lone 0x20 user.
        if (f3 == `FUNCT3_SLL)     bad = (f7 != 7'h00);
        if (f3 == `FUNCT3_SRL_SRA) bad = (f7 != 7'h00) && (f7 != 7'h20);
      end
      `OPCODE_OP:     begin
        cls = CLS_OP;
        bad = !((f7 == 7'h00) ||
                ((f7 == 7'h20) && (f3 inside {`FUNCT3_ADD_SUB, `FUNCT3_SRL_SRA})));
      end
      `OPCODE_FENCE:  cls = CLS_FENCE;
      `OPCODE_SYSTEM: cls = CLS_SYSTEM;
      default:        cls = CLS_ILLEGAL;
    endcase
    if (bad || in_instr[1:0] != 2'b11) cls = CLS_ILLEGAL;

    dec_d          = '0;
    dec_d.pc       = in_pc;
    dec_d.rd       = in_instr[11:7];
    dec_d.rs1      = in_instr[19:15];
    dec_d.rs2      = in_instr[24:20];
    dec_d.funct3   = f3;
    dec_d.funct7_5 = in_instr[30];
    dec_d.op_class = cls;
    dec_d.illegal  = (cls == CLS_ILLEGAL);
    case (cls)
      CLS_LUI, CLS_AUIPC: begin dec_d.imm = imm_u; dec_d.is_imm = 1'b1; end
      CLS_JAL:            begin dec_d.imm = imm_j; dec_d.is_imm = 1'b1; end
      CLS_JALR, CLS_OP_IMM: begin dec_d.imm = imm_i; dec_d.is_imm = 1'b1; end
      CLS_LOAD:           begin dec_d.imm = imm_i; dec_d.is_imm = 1'b1; dec_d.mem_read = 1'b1; end
      CLS_STORE:          begin dec_d.imm = imm_s; dec_d.is_imm = 1'b1; dec_d.mem_write = 1'b1; end
      CLS_BRANCH:         begin dec_d.imm = imm_b; dec_d.is_imm = 1'b1; end
      default:            dec_d.imm = '0;
    endcase
    // Writes to x0 are dropped here so downstream never has to check rd.
    dec_d.reg_write = (cls inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LOAD,
                                   CLS_OP_IMM, CLS_OP}) && (in_instr[11:7] != 5'd0);
  end

  // ---------------- output register + skid register ----------------
  logic accept, xfer;
  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q         <= '0;
      skid_q        <= '0;
      out_valid     <= 1'b0;
      skid_valid    <= 1'b0;
      in_ready      <= 1'b1;
      decoded_count <= '0;
      illegal_count <= '0;
    end else begin
      // A transfer on the flush edge already happened, so it is still counted.
      if (xfer) begin
        decoded_count <= decoded_count + CNT_WIDTH'(1);
        if (out_q.illegal && illegal_count != 16'hFFFF)
          illegal_count <= illegal_count + 16'd1;
      end
      if (flush) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else if (!out_valid || out_ready) begin
        // Output is free or draining. The skid entry is older, so it goes first.
        // No accept can coincide with a full skid because in_ready is low then.
        if (skid_valid) begin
          out_q      <= skid_q;
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
          in_ready   <= 1'b1;
        end else if (accept) begin
          out_q     <= dec_d;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_q     <= dec_d;
        skid_valid <= 1'b1;
        in_ready   <= 1'b0;
      end
    end
  end

  assign out_pc    = out_q.pc;
  assign rd        = out_q.rd;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign funct3    = out_q.funct3;
  assign funct7_5  = out_q.funct7_5;
  assign imm       = out_q.imm;
  assign op_class  = out_q.op_class;
  assign reg_write = out_q.reg_write;
  assign mem_read  = out_q.mem_read;
  assign mem_write = out_q.mem_write;
  assign is_imm    = out_q.is_imm;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7_5, reg_write, mem_read, mem_write, is_imm, illegal;
  logic [3:0]  op_class;
  logic [31:0] decoded_count;
  logic [15:0] illegal_count;

  int n_vec = 0, n_err = 0;
  int exp_dec = 0, exp_ill = 0;

  instr_decode_stage #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7_5(funct7_5),
    .imm(imm), .op_class(op_class), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .is_imm(is_imm), .illegal(illegal),
    .decoded_count(decoded_count), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction through an idle stage with out_ready=1.
  task automatic vec(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [3:0] cls, input logic [31:0] im,
                     input logic rw, input logic mr, input logic mw,
                     input logic ii, input logic ill);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    step();
    in_valid = 1'b0;
    chk({tag, ".vld"},   32'(out_valid), 32'd1);
    chk({tag, ".cls"},   32'(op_class),  32'(cls));
    chk({tag, ".imm"},   imm,            im);
    chk({tag, ".pc"},    out_pc,         pc);
    chk({tag, ".rw"},    32'(reg_write), 32'(rw));
    chk({tag, ".mr"},    32'(mem_read),  32'(mr));
    chk({tag, ".mw"},    32'(mem_write), 32'(mw));
    chk({tag, ".isimm"}, 32'(is_imm),    32'(ii));
    chk({tag, ".ill"},   32'(illegal),   32'(ill));
    chk({tag, ".rd"},    32'(rd),        32'(ins[11:7]));
    chk({tag, ".rs1"},   32'(rs1),       32'(ins[19:15]));
    chk({tag, ".rs2"},   32'(rs2),       32'(ins[24:20]));
    chk({tag, ".f3"},    32'(funct3),    32'(ins[14:12]));
    chk({tag, ".f75"},   32'(funct7_5),  32'(ins[30]));
    step();
    exp_dec++;
    if (ill) exp_ill++;
    chk({tag, ".dcnt"},  decoded_count,      32'(exp_dec));
    chk({tag, ".icnt"},  32'(illegal_count), 32'(exp_ill));
    chk({tag, ".drain"}, 32'(out_valid),     32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    step(); step();
    chk("rst.vld",  32'(out_valid), 32'd0);
    chk("rst.rdy",  32'(in_ready),  32'd1);
    chk("rst.cls",  32'(op_class),  32'd0);
    chk("rst.imm",  imm,            32'd0);
    chk("rst.dcnt", decoded_count,  32'd0);
    chk("rst.icnt", 32'(illegal_count), 32'd0);
    rst = 1'b0;
    step();

    //   tag       instr         pc     cls  imm           rw mr mw ii ill
    vec("addi",   32'h00500193, 32'h00, 4'd7,  32'h00000005, 1, 0, 0, 1, 0);
    vec("lb",     32'h00100303, 32'h04, 4'd5,  32'h00000001, 1, 1, 0, 1, 0);
    vec("lui",    32'hFFFFF137, 32'h08, 4'd0,  32'hFFFFF000, 1, 0, 0, 1, 0);
    vec("beq",    32'hFE000EE3, 32'h10, 4'd4,  32'hFFFFFFFC, 0, 0, 0, 1, 0);
    vec("sw",     32'h00512423, 32'h14, 4'd6,  32'h00000008, 0, 0, 1, 1, 0);
    vec("jal",    32'h010000EF, 32'h18, 4'd2,  32'h00000010, 1, 0, 0, 1, 0);
    vec("sub",    32'h407302B3, 32'h1C, 4'd8,  32'h00000000, 1, 0, 0, 0, 0);
    vec("srai",   32'h4030D093, 32'h20, 4'd7,  32'h00000403, 1, 0, 0, 1, 0);
    vec("nop",    32'h00000013, 32'h24, 4'd7,  32'h00000000, 0, 0, 0, 1, 0);
    vec("auipc",  32'h00001297, 32'h28, 4'd1,  32'h00001000, 1, 0, 0, 1, 0);
    vec("fence",  32'h0000000F, 32'h2C, 4'd9,  32'h00000000, 0, 0, 0, 0, 0);
    vec("ecall",  32'h00000073, 32'h30, 4'd10, 32'h00000000, 0, 0, 0, 0, 0);
    vec("zero",   32'h00000000, 32'h34, 4'd15, 32'h00000000, 0, 0, 0, 0, 1);
    vec("f7one",  32'h02000033, 32'h38, 4'd15, 32'h00000000, 0, 0, 0, 0, 1);
    vec("slli20", 32'h40001013, 32'h3C, 4'd15, 32'h00000000, 0, 0, 0, 0, 1);
    vec("jalrf3", 32'h000010E7, 32'h40, 4'd15, 32'h00000000, 0, 0, 0, 0, 1);

    // Backpressure: A to out, B to skid, C held off, then in-order drain.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h100;
    step();
    chk("bp.a.rdy", 32'(in_ready), 32'd1);
    chk("bp.a.pc",  out_pc,        32'h100);
    in_instr = 32'h00200093; in_pc = 32'h104;
    step();
    chk("bp.b.rdy", 32'(in_ready), 32'd0);
    chk("bp.b.vld", 32'(out_valid), 32'd1);
    in_instr = 32'h00300093; in_pc = 32'h108;
    step();
    chk("bp.hold.rdy", 32'(in_ready), 32'd0);
    chk("bp.hold.pc",  out_pc,        32'h100);
    chk("bp.hold.imm", imm,           32'd1);
    out_ready = 1'b1;
    step();
    chk("bp.out2.pc",  out_pc,        32'h104);
    chk("bp.out2.imm", imm,           32'd2);
    chk("bp.out2.rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp.out3.pc",  out_pc, 32'h108);
    chk("bp.out3.imm", imm,    32'd3);
    step();
    exp_dec += 3;
    chk("bp.end.vld",  32'(out_valid), 32'd0);
    chk("bp.end.dcnt", decoded_count,  32'(exp_dec));

    // Flush with two stalled entries and a new input presented the same cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h200;
    step();
    in_pc = 32'h204;
    step();
    chk("fl.full.rdy", 32'(in_ready), 32'd0);
    flush = 1'b1; in_pc = 32'h208;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl.vld",  32'(out_valid), 32'd0);
    chk("fl.rdy",  32'(in_ready),  32'd1);
    chk("fl.dcnt", decoded_count,  32'(exp_dec));
    chk("fl.icnt", 32'(illegal_count), 32'(exp_ill));
    step();
    chk("fl.discard.vld", 32'(out_valid), 32'd0);

    // Flush coinciding with an output transfer: the transfer still counts.
    in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h300;
    step();
    in_valid = 1'b0;
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    exp_dec++; exp_ill++;
    chk("flx.vld",  32'(out_valid), 32'd0);
    chk("flx.dcnt", decoded_count,  32'(exp_dec));
    chk("flx.icnt", 32'(illegal_count), 32'(exp_ill));

    // Reset mid-operation beats flush and handshakes.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFFFF137; in_pc = 32'h400;
    step();
    in_pc = 32'h404;
    step();
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("rst2.vld",  32'(out_valid), 32'd0);
    chk("rst2.rdy",  32'(in_ready),  32'd1);
    chk("rst2.pc",   out_pc,         32'd0);
    chk("rst2.imm",  imm,            32'd0);
    chk("rst2.dcnt", decoded_count,  32'd0);
    chk("rst2.icnt", 32'(illegal_count), 32'd0);
    step();
    chk("rst2.after.vld", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
